// File: rtl/value_seq_detect_if.sv
// Symbol stream in, match pulse/count/fill out, grouped for the detector.
// Latency: n/a (wiring only).
// Backpressure: none; the upstream qualifies symbols with in_valid only.
interface value_seq_detect_if #(
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic [1:0]       in;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic [2:0]       fill;

  // Upstream / stimulus side
  modport master (
    output in_valid, in, clr,
    input  match, match_cnt, fill
  );

  // Detector side
  modport slave (
    input  in_valid, in, clr,
    output match, match_cnt, fill
  );
endinterface

// File: rtl/value_seq_detect.sv
// Detects a programmable 4-symbol sequence (overlapping) in a qualified 2-bit stream.
// Latency: match pulses 1 cycle after the edge accepting the 4th symbol; all outputs registered.
// Backpressure: none; symbols are accepted on every edge with in_valid=1.
module value_seq_detect #(
  parameter logic [7:0] PATTERN = 8'b00_01_10_11,
  parameter int         CNT_W   = 8
) (
  input  logic              sys_clock,
  input  logic              sys_rst,
  value_seq_detect_if.slave bus
);

  logic [7:0]       hist_q;
  logic [2:0]       fill_q;
  logic             match_q;
  logic [CNT_W-1:0] cnt_q;

  logic [7:0]       next_hist;
  logic             hit;

  // History as it would look after accepting the current symbol, and whether that
  // completes the pattern; fill gating stops reset zeros from forming a false match.
  always_comb begin
    next_hist = {hist_q[5:0], bus.in};
    hit       = (fill_q >= 3'd3) && (next_hist == PATTERN);
  end

  // State update: reset beats clr beats accept; a symbol arriving with clr is dropped.
  always_ff @(posedge sys_clock) begin
    if (sys_rst || bus.clr) begin
      hist_q  <= 8'd0;
      fill_q  <= 3'd0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.in_valid) begin
      hist_q  <= next_hist;
      if (fill_q != 3'd4) begin
        fill_q <= fill_q + 3'd1;
      end
      match_q <= hit;
      if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      match_q <= 1'b0;
    end
  end

  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.fill      = fill_q;

endmodule
